// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Buffers a parallel byte stream in a small FIFO and drives it onto an
//   asynchronous serial line as 8N1 frames at a fixed bit period. Frames are
//   sent back to back, with no idle gap, while the FIFO holds data.
//
// Ports
//   clk         system clock; all logic runs on the rising edge
//   reset       asynchronous, active-high reset
//   tx_data     byte to transmit
//   tx_valid    tx_data is valid this cycle
//   tx_ready    FIFO can accept a byte this cycle (combinational !full)
//   tx_serial   serial line, idle high (registered)
//   busy        a frame is in progress (registered)
//   fifo_count  number of bytes currently buffered (registered)
//   overflow    sticky: a byte was offered while the FIFO was full (registered)
//
// Option
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      last data bit and the stop bit (11-bit frame).
//
// state  | meaning
// IDLE   | line high, waiting for a buffered byte
// START  | start bit (low) for one bit period
// DATA   | eight data bits, LSB first, one bit period each
// PARITY | even parity bit (only with UART_TX_PARITY_EN)
// STOP   | stop bit (high); then next frame or IDLE
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_serial_q, tx_serial_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic full;
  logic push;
  logic pop;
  logic bit_done;
  logic [7:0] head;

  assign full     = (count_q == CNT_FULL);
  assign push     = tx_valid && !full;
  assign bit_done = (timer_q == TMR_LAST);
  assign head     = mem_q[rd_ptr_q];

  assign tx_ready   = !full;
  assign tx_serial  = tx_serial_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_START;
          timer_d = '0;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          timer_d   = '0;
          bit_idx_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          timer_d = '0;
          // Chain straight into the next start bit so frames abut.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = S_START;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are registered, so the line level is derived from the next state.
  always_comb begin
    tx_serial_d = 1'b1;
    case (state_d)
      S_START:  tx_serial_d = 1'b0;
      S_DATA:   tx_serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_serial_d = parity_d;
`endif
      default:  tx_serial_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    overflow_d = overflow_q | (tx_valid && full);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_serial_q <= tx_serial_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A frame-level reference model tracks the buffered bytes and the time left
// in the current frame; a separate monitor decodes frames off the line and
// compares them against the bytes the model says were accepted.
module tb_uart_tx_serializer;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;
  localparam int NS    = FRAME;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_serial;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_serial  (tx_serial),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: bytes waiting, cycles left in the current frame.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         m_left = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_ovf = 1'b0;
  int         m_pre;
  logic       m_acc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
    end else begin
      m_pre = mq.size();
      m_acc = tx_valid && (m_pre < DEPTH);
      if (tx_valid && !m_acc) m_ovf = 1'b1;
      if (m_left > 0) m_left--;
      if (m_left == 0 && m_pre > 0) begin
        m_cur  = mq.pop_front();
        m_left = FRAME;
      end
      if (m_acc) begin
        mq.push_back(tx_data);
        exp_q.push_back(tx_data);
      end
    end
  end

  function automatic logic exp_line();
    int pos;
    int b;
    if (m_left == 0) return 1'b1;
    pos = FRAME - m_left;
    b   = pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    chk("tx_serial",  32'(tx_serial),  32'(exp_line()));
    chk("busy",       32'(busy),       32'(m_left > 0));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("tx_ready",   32'(tx_ready),   32'(mq.size() < DEPTH));
    chk("overflow",   32'(overflow),   32'(m_ovf));
  end

  // Monitor: decode each frame and compare against the next accepted byte.
  logic [NS-1:0]  smp;
  logic           aborted;
  logic [7:0]     eb;
  logic [7:0]     got;
  logic           ebit;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_serial === 1'b0) begin
        aborted = 1'b0;
        smp     = '0;
        for (int i = 1; i < NS; i++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          smp[i] = tx_serial;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", 32'd1, 32'd0);
          end else begin
            eb  = exp_q.pop_front();
            got = 8'h00;
            for (int b = 0; b < FRAME_BITS; b++) begin
              if (b == 0) ebit = 1'b0;
              else if (b <= 8) ebit = eb[b-1];
`ifdef UART_TX_PARITY_EN
              else if (b == 9) ebit = ^eb;
`endif
              else ebit = 1'b1;
              chk("frame_bit", 32'(smp[b*CPB +: CPB]), 32'({CPB{ebit}}));
              if (b >= 1 && b <= 8) got[b-1] = smp[b*CPB];
            end
            chk("frame_byte", 32'(got), 32'(eb));
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    #1;
    tx_valid = v;
    tx_data  = d;
  endtask

  task automatic push_honour(input logic [7:0] d);
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      #1;
      if (tx_ready) begin
        tx_valid = 1'b1;
        tx_data  = d;
        return;
      end
      tx_valid = 1'b0;
    end
    chk("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (m_left == 0 && mq.size() == 0) break;
    end
    if (n >= 3000) chk("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset    = 1'b1;
    tx_valid = 1'b0;
    #1;
    chk("rst_tx_serial",  32'(tx_serial),  32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_tx_ready",   32'(tx_ready),   32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("init_tx_serial",  32'(tx_serial),  32'd1);
    chk("init_busy",       32'(busy),       32'd0);
    chk("init_fifo_count", 32'(fifo_count), 32'd0);
    chk("init_overflow",   32'(overflow),   32'd0);
    chk("init_tx_ready",   32'(tx_ready),   32'd1);
    #1;
    reset = 1'b0;

    // single byte
    drive(1'b1, 8'hA5);
    drive(1'b0, 8'h00);
    drain();

    // six-cycle burst into a four-deep FIFO: last byte dropped
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h10 + i));
    drive(1'b0, 8'h00);
    drain();
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // ten bytes honouring back-pressure, pointers wrap
    do_reset();
    for (int i = 0; i < 10; i++) push_honour(8'(i));
    drive(1'b0, 8'h00);
    drain();
    chk("wrap_overflow", 32'(overflow), 32'd0);
    chk("wrap_count",    32'(fifo_count), 32'd0);

    // reset in the middle of a frame with bytes queued
    drive(1'b1, 8'h3C);
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    drive(1'b0, 8'h00);
    repeat (10) @(negedge clk);
    do_reset();
    repeat (60) @(negedge clk);
    chk("post_reset_idle", 32'(tx_serial), 32'd1);

    // all-zeros then all-ones back to back
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    drive(1'b0, 8'h00);
    drain();

`ifdef UART_TX_PARITY_EN
    drive(1'b1, 8'h07);
    drive(1'b1, 8'h03);
    drive(1'b0, 8'h00);
    drain();
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 400; i++) drive(($urandom_range(0, 9) == 0), 8'($urandom));
    drive(1'b0, 8'h00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
